// File: rtl/fifo_pkg.sv
// Shared types and constants for the fifo read-side stream adapter.
`timescale 1ns/1ps
package fifo_pkg;
    localparam int FIFO_WIDTH   = 24;
    localparam int RD_BUF_DEPTH = 2;
    localparam int RD_CNT_W     = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: head drives the stream, tail absorbs a word that
// lands while the head is held by backpressure.
`timescale 1ns/1ps
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output occ_e             occ_o
);
    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            EMPTY: begin
                if (cap_i) begin
                    head_d = din_i;
                    occ_d  = ONE;
                end
            end
            ONE: begin
                if (cap_i && pop_i) begin
                    head_d = din_i;
                end else if (cap_i) begin
                    tail_d = din_i;
                    occ_d  = TWO;
                end else if (pop_i) begin
                    occ_d = EMPTY;
                end
            end
            TWO: begin
                // Capture without pop cannot happen here: the credit rule forbids it.
                if (pop_i) begin
                    head_d = tail_q;
                    if (cap_i) tail_d = din_i;
                    else       occ_d  = ONE;
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= EMPTY;
            head_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

    assign head_o  = head_q;
    assign valid_o = (occ_q != EMPTY);
    assign occ_o   = occ_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read adapter: issues credit-limited reads and presents words on a
// valid/ready stream. Optional delivered-word counter under FIFO_RD_CNT_EN.
`timescale 1ns/1ps
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_rd,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [RD_CNT_W-1:0] rd_count
`endif
);
    logic       inflight_q;
    logic       pop;
    occ_e       occ;
    logic [1:0] committed;

    assign pop = m_valid && m_ready;

    // Words buffered or in flight after this cycle's pop; a new read needs a free slot.
    assign committed = 2'(occ) + {1'b0, inflight_q} - {1'b0, pop};
    assign fifo_rd   = !rst && !fifo_empty && (committed < 2'(RD_BUF_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight_q <= 1'b0;
        else     inflight_q <= fifo_rd;
    end

    fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .cap_i   (inflight_q),
        .pop_i   (pop),
        .din_i   (fifo_dout),
        .head_o  (m_data),
        .valid_o (m_valid),
        .occ_o   (occ)
    );

`ifdef FIFO_RD_CNT_EN
    logic [RD_CNT_W-1:0] rd_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      rd_count_q <= '0;
        else if (pop) rd_count_q <= rd_count_q + 1'b1;
    end

    assign rd_count = rd_count_q;
`endif

    credit_ok: assert property (@(posedge clk) disable iff (rst)
        (3'(occ) + 3'(inflight_q)) <= 3'(RD_BUF_DEPTH));
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised scoreboard bench for fifo_rd_stream with a queue-based FIFO model.
`timescale 1ns/1ps
module tb_fifo_rd_stream;
    import fifo_pkg::*;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fifo_rd;
    logic [W-1:0] fifo_dout = '0;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
`ifdef FIFO_RD_CNT_EN
    logic [15:0]  rd_count;
`endif

    fifo_rd_stream #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_rd    (fifo_rd),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count   (rd_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] fq[$];
    logic [W-1:0] exp_mem [256];
    int   n_read = 0;
    int   n_seen = 0;
    int   cnt_model = 0;
    logic rd_prev = 1'b0;
    int   mode = 0;
    int   cyc = 0;
    int   budget = 0;
    bit   autofill = 1'b0;
    int   rd_pulses, hs_cnt, v_cnt, first_rd, first_v, last_v;

    task automatic chk(input string name, input logic ok, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic clear_stats();
        rd_pulses = 0; hs_cnt = 0; v_cnt = 0;
        first_rd = -1; first_v = -1; last_v = -1;
    endtask

    // One clock cycle: FIFO returns the word read last cycle, inputs change, then sample.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rd_prev && fq.size() > 0) begin
            fifo_dout = fq.pop_front();
            exp_mem[n_read % 256] = fifo_dout;
            n_read++;
        end else begin
            fifo_dout = W'($urandom);
        end
        if (autofill && fq.size() < 4) fq.push_back(W'($urandom));
        fifo_empty = (fq.size() == 0);
        case (mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = 1'($urandom % 2);
            default: m_ready = (budget > 0);
        endcase
        #1;
        rd_prev = fifo_rd;
        if (fifo_rd) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid) begin
            v_cnt++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (m_valid && m_ready) begin
            hs_cnt++;
            if (budget > 0) budget--;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        #1;
        rd_prev = fifo_rd;
        chk("rst_valid_now", m_valid == 1'b0, 32'(m_valid), 0);
        chk("rst_data_now", m_data == '0, 32'(m_data), 0);
        chk("rst_rd_now", fifo_rd == 1'b0, 32'(fifo_rd), 0);
        repeat (cycles) step();
        rst = 1'b0;
        #1;
        rd_prev = fifo_rd;
    endtask

    task automatic drain(input string name);
        int k = 0;
        mode = 1;
        while (!(fq.size() == 0 && n_seen == n_read && !rd_prev && !m_valid) && k < 200) begin
            step();
            k++;
        end
        chk(name, k < 200, 32'(k), 200);
    endtask

    logic [W-1:0] hold_data = '0;
    logic         hold_pend = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            n_seen    = n_read;
            cnt_model = 0;
            hold_pend = 1'b0;
        end else begin
            if (fifo_empty) chk("rd_when_empty", fifo_rd == 1'b0, 32'(fifo_rd), 0);
            if (hold_pend) chk("hold_stable", m_valid && (m_data == hold_data), 32'(m_data), 32'(hold_data));
            if (m_valid && m_ready) begin
                if (n_seen >= n_read) begin
                    chk("unexpected_word", 1'b0, 32'(m_data), 0);
                end else begin
                    chk("data", m_data == exp_mem[n_seen % 256], 32'(m_data), 32'(exp_mem[n_seen % 256]));
                    n_seen++;
                end
`ifdef FIFO_RD_CNT_EN
                chk("rd_count_run", rd_count == 16'(cnt_model), 32'(rd_count), 32'(16'(cnt_model)));
                cnt_model++;
`endif
            end
            hold_pend = m_valid && !m_ready;
            hold_data = m_data;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        repeat (3) step();
        chk("reset_valid", m_valid == 1'b0, 32'(m_valid), 0);
        chk("reset_data", m_data == '0, 32'(m_data), 0);
        chk("reset_rd", fifo_rd == 1'b0, 32'(fifo_rd), 0);
`ifdef FIFO_RD_CNT_EN
        chk("reset_count", rd_count == 16'd0, 32'(rd_count), 0);
`endif
        rst = 1'b0;
        #1;
        rd_prev = fifo_rd;

        // Streaming at full rate
        for (int i = 0; i < 16; i++) fq.push_back(24'h123450 + W'(i));
        mode = 1;
        clear_stats();
        repeat (24) step();
        chk("stream_latency", (first_v - first_rd) == 2, 32'(first_v - first_rd), 2);
        chk("stream_count", hs_cnt == 16, 32'(hs_cnt), 16);
        chk("stream_contiguous", (last_v - first_v) == 15, 32'(last_v - first_v), 15);

        // Full backpressure
        mode = 0;
        clear_stats();
        for (int i = 0; i < 5; i++) fq.push_back(24'hABCDEF + W'(i));
        repeat (10) step();
        chk("bp_rd_pulses", rd_pulses == 2, 32'(rd_pulses), 2);
        chk("bp_head", m_valid && (m_data == 24'hABCDEF), 32'(m_data), 32'h00ABCDEF);
        mode = 1;
        clear_stats();
        repeat (5) step();
        chk("bp_no_gaps", hs_cnt == 5, 32'(hs_cnt), 5);
        drain("bp_drain");

        // Empty FIFO
        mode = 2;
        clear_stats();
        repeat (20) step();
        chk("empty_no_rd", rd_pulses == 0, 32'(rd_pulses), 0);
        chk("empty_no_valid", v_cnt == 0, 32'(v_cnt), 0);

        // Single word, random ready
        fq.push_back(24'h555555);
        clear_stats();
        repeat (30) step();
        mode = 1;
        repeat (5) step();
        chk("single_rd", rd_pulses == 1, 32'(rd_pulses), 1);
        chk("single_xfer", hs_cnt == 1, 32'(hs_cnt), 1);

        // Reset with two words buffered
        mode = 0;
        clear_stats();
        for (int i = 0; i < 8; i++) fq.push_back(24'h700000 + W'(i));
        repeat (6) step();
        chk("pre_rst_valid", m_valid == 1'b1, 32'(m_valid), 1);
        do_reset(2);
`ifdef FIFO_RD_CNT_EN
        chk("rst_count_clear", rd_count == 16'd0, 32'(rd_count), 0);
`endif
        chk("rst_fifo_left", fq.size() == 6, 32'(fq.size()), 6);
        mode = 1;
        clear_stats();
        repeat (12) step();
        chk("rst_resume_count", hs_cnt == 6, 32'(hs_cnt), 6);

        // Random traffic
        mode = 2;
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 3) == 0 && fq.size() < 20) fq.push_back(W'($urandom));
            step();
        end
        drain("random_drain");

`ifdef FIFO_RD_CNT_EN
        // Counter wrap
        do_reset(2);
        autofill = 1'b1;
        budget   = 65537;
        mode     = 3;
        begin
            int k = 0;
            while (budget > 0 && k < 70000) begin
                step();
                k++;
            end
            chk("wrap_budget", budget == 0, 32'(budget), 0);
        end
        autofill = 1'b0;
        mode     = 0;
        repeat (4) step();
        chk("wrap_count", rd_count == 16'd1, 32'(rd_count), 1);
        drain("wrap_drain");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter for the team's synchronous `fifo` (WIDTH/DEPTH parameterised, `rd`/`dout`/`empty` port set). It pops words from the FIFO and presents them on a registered valid/ready output stream, absorbing the FIFO's one-cycle read latency with a 2-entry output buffer. It sits between a FIFO and any downstream consumer, such as a serializer or DSP stage, that applies backpressure. It sustains one word per cycle when `m_ready` is held high.

## Interface
- `WIDTH`, 24: data word width; must match the attached FIFO.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fifo_rd` out 1: read strobe to the FIFO `rd` input.
- `fifo_dout` in WIDTH: FIFO `dout`; valid in the cycle after a `fifo_rd` that was issued while `fifo_empty`=0.
- `fifo_empty` in 1: FIFO `empty` flag.
- `m_data` out WIDTH: output word; registered.
- `m_valid` out 1: `m_data` holds a word.
- `m_ready` in 1: consumer accepts; a transfer occurs when `m_valid && m_ready` at a rising edge.
- `rd_count` out 16: words delivered; present only with `FIFO_RD_CNT_EN`.

## Operation
- State is `occ` (0..2 words buffered; head drives `m_data`) plus `inflight` (1 bit, a read was issued last cycle).
- `fifo_rd` = `!fifo_empty && (occ + inflight - (m_valid && m_ready)) < 2`. It is combinational from registered state, `fifo_empty` and `m_ready`.
- `inflight` <= `fifo_rd` each cycle. `fifo_rd` is never asserted while `fifo_empty`=1, so every in-flight read returns data.
- When `inflight`=1, `fifo_dout` is written into the buffer:
  - into head if `occ`=0, or if `occ`=1 and the head is popped in the same cycle;
  - otherwise into the tail slot.
- On a pop with `occ`=2, the tail moves to the head.
- Buffer states: EMPTY (`occ`=0), ONE, TWO. Transitions:
  - +1 on capture without pop;
  - −1 on pop without capture;
  - unchanged on capture and pop together.
- `m_valid` = (`occ` != 0).
- Order is strictly FIFO; no word is dropped or duplicated.
- `m_data` must not change while `m_valid`=1 and `m_ready`=0.
- The credit rule guarantees `occ + inflight` ≤ 2, so overflow cannot occur. The implementation asserts this in simulation.

## Timing
- Reset values: `fifo_rd`=0 (from state), `m_valid`=0, `m_data`=0, `occ`=0, `inflight`=0, `rd_count`=0.
- Latency: `fifo_empty` falls in cycle N, `fifo_rd`=1 in N, data arrives in N+1, `m_valid`=1 in N+2.
- Throughput: 1 word/cycle with `m_ready`=1 and the FIFO non-empty.
- Backpressure: with `m_ready`=0 the block stops issuing `fifo_rd` once `occ + inflight` reaches 2. At most 2 words are buffered.
- Same-cycle events:
  - FIFO becomes empty: `fifo_rd` drops the same cycle `fifo_empty` rises. There are no reads into an empty FIFO.
  - Pop, capture and new read together: all are legal in one cycle.
- Reset mid-operation: buffered and in-flight words are discarded, since they are already removed from the FIFO. Outputs return to reset values immediately.

## Configuration
- `FIFO_RD_CNT_EN` defined:
  - `rd_count` port exists;
  - it increments by 1 on each `m_valid && m_ready` and wraps 0xFFFF→0;
  - it is cleared by `rst`.
- `FIFO_RD_CNT_EN` undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- A shared package `fifo_pkg` holds:
  - default `WIDTH` (24);
  - `RD_BUF_DEPTH` = 2;
  - the occupancy enum EMPTY/ONE/TWO;
  - `RD_CNT_W` = 16.
- One natural sub-module, `fifo_rd_skid`: the 2-entry buffer, with capture/pop inputs and head/valid outputs. The top holds the credit logic and counter.

## Test plan
- **Streaming:** FIFO (WIDTH 24, DEPTH 16) preloaded with 0x123450–0x12345F, `m_ready`=1 → `m_data` sequence 0x123450..0x12345F on 16 consecutive cycles. The first `m_valid` occurs 2 cycles after the first `fifo_rd`.
- **Full backpressure:** FIFO holds 0xABCDEF–0xABCDF3, `m_ready`=0 → exactly 2 `fifo_rd` pulses and `m_data`=0xABCDEF stable. When `m_ready` rises, the remaining words follow in order with no gaps.
- **Empty FIFO:** `fifo_empty`=1 throughout → `fifo_rd` never asserts and `m_valid` stays 0.
- **Single word with random `m_ready`:** FIFO holds only 0x555555, `m_ready` toggled pseudo-randomly → exactly one transfer of 0x555555 and no read while empty.
- **Reset mid-stream:** `rst` pulsed mid-stream with `occ`=2 → `m_valid`=0 immediately. After release, streaming resumes with the next FIFO word, and `rd_count`=0 when `FIFO_RD_CNT_EN` is defined.
- **Counter wrap:** with `FIFO_RD_CNT_EN`, 65537 transfers → `rd_count`=1.
